// File: rtl/lbdr_param.sv
// lbdr_param: parametrised LBDR routing unit for one router input port, with packet FSM,
// runtime configuration, protocol-error detection and a completed-packet counter.
// Optional build macro LBDR_DEROUTE_EN adds a configurable deroute port for blocked headers.
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module lbdr_param #(
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter logic [X_W+Y_W-1:0] CUR_ADDR_RST = (X_W+Y_W)'(32'd5),
  parameter logic [7:0] RXY_RST = 8'd60,
  parameter logic [3:0] CX_RST = 4'd15,
`ifdef LBDR_DEROUTE_EN
  parameter logic [1:0] DR_RST = 2'd0,
`endif
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [7:0]         Rxy_cfg,
  input  logic [3:0]         Cx_cfg,
  input  logic [X_W+Y_W-1:0] cur_addr_cfg,
`ifdef LBDR_DEROUTE_EN
  input  logic [1:0]         dr,
`endif
  input  logic               empty,
  input  logic               rd,
  input  logic [2:0]         flit_id,
  input  logic [X_W+Y_W-1:0] dst_addr,
  output logic               Nport,
  output logic               Eport,
  output logic               Wport,
  output logic               Sport,
  output logic               Lport,
  output logic               route_valid,
  output logic               no_route,
  output logic               proto_err,
  output logic [CNT_W-1:0]   pkt_cnt
);

  localparam int AW = X_W + Y_W;

  typedef enum logic {ST_IDLE = 1'b0, ST_ROUTE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       rxy_q, rxy_d;
  logic [3:0]       cx_q, cx_d;
  logic [AW-1:0]    cur_q, cur_d;
  logic [4:0]       ports_q, ports_d;      // {N,E,W,S,L}
  logic             rv_q, rv_d;
  logic             no_route_q, no_route_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hdr_pend_q, hdr_pend_d;
`ifdef LBDR_DEROUTE_EN
  logic [1:0]       dr_q, dr_d;
`endif

  logic [4:0] min_route_s;
  logic [4:0] hdr_route_s;
  logic       is_hdr_s;
  logic       new_hdr_s;
  logic       tail_s;
  logic       eval_hdr_s;

  // Minimal LBDR port equations; rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, cx = {Cs,Cw,Ce,Cn}.
  function automatic logic [4:0] min_route_f(
    input logic [AW-1:0] dst,
    input logic [AW-1:0] cur,
    input logic [7:0]    rxy,
    input logic [3:0]    cx
  );
    logic [X_W-1:0] xd;
    logic [X_W-1:0] xc;
    logic [Y_W-1:0] yd;
    logic [Y_W-1:0] yc;
    logic n1, e1, w1, s1;
    logic n, e, w, s, l;
    xd = dst[X_W-1:0];
    yd = dst[AW-1:X_W];
    xc = cur[X_W-1:0];
    yc = cur[AW-1:X_W];
    n1 = (yd < yc);
    s1 = (yc < yd);
    e1 = (xc < xd);
    w1 = (xd < xc);
    n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
    e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
    w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
    s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];
    l = ~n1 & ~e1 & ~w1 & ~s1;
    return {n, e, w, s, l};
  endfunction

`ifdef LBDR_DEROUTE_EN
  // An all-zero result is never local, so it is replaced by the connected deroute port.
  function automatic logic [4:0] deroute_f(
    input logic [4:0] r,
    input logic [1:0] drc,
    input logic [3:0] cx
  );
    logic [4:0] o;
    o = r;
    if (r == 5'b00000) begin
      case (drc)
        2'd0:    o = {cx[0], 4'b0000};
        2'd1:    o = {1'b0, cx[1], 3'b000};
        2'd2:    o = {2'b00, cx[2], 2'b00};
        2'd3:    o = {3'b000, cx[3], 1'b0};
        default: o = 5'b00000;
      endcase
    end else begin
      o = r;
    end
    return o;
  endfunction
`endif

  // Flit decode and header route evaluated against the currently registered config.
  always_comb begin
    is_hdr_s    = ~empty & (flit_id == `HEADER);
    tail_s      = rd & ~empty & (flit_id == `TAIL);
    // A header still parked at the FIFO head after evaluation is not a second header.
    new_hdr_s   = is_hdr_s & ~hdr_pend_q;
    min_route_s = min_route_f(dst_addr, cur_q, rxy_q, cx_q);
`ifdef LBDR_DEROUTE_EN
    hdr_route_s = deroute_f(min_route_s, dr_q, cx_q);
`else
    hdr_route_s = min_route_s;
`endif
    if (state_q == ST_IDLE) begin
      eval_hdr_s = is_hdr_s;
    end else begin
      eval_hdr_s = new_hdr_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_hdr_s) begin
          state_d = ST_ROUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROUTE: begin
        if (new_hdr_s) begin
          state_d = ST_ROUTE;
        end else if (tail_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ROUTE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values per state.
  always_comb begin
    ports_d     = ports_q;
    rv_d        = rv_q;
    no_route_d  = no_route_q;
    proto_err_d = proto_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (is_hdr_s) begin
          ports_d    = hdr_route_s;
          rv_d       = 1'b1;
          no_route_d = no_route_q | (hdr_route_s == 5'b00000);
        end else if (~empty) begin
          proto_err_d = 1'b1;
        end else begin
          ports_d = ports_q;
        end
      end
      ST_ROUTE: begin
        if (new_hdr_s) begin
          proto_err_d = 1'b1;
          ports_d     = hdr_route_s;
          rv_d        = 1'b1;
          no_route_d  = no_route_q | (hdr_route_s == 5'b00000);
        end else if (tail_s) begin
          ports_d = 5'b00000;
          rv_d    = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1'b1);
        end else begin
          ports_d = ports_q;
        end
      end
      default: begin
        ports_d = 5'b00000;
        rv_d    = 1'b0;
      end
    endcase
  end

  // Header-pending tracking and configuration next values.
  always_comb begin
    hdr_pend_d = hdr_pend_q;
    if (eval_hdr_s) begin
      hdr_pend_d = ~rd;
    end else if (rd & ~empty) begin
      hdr_pend_d = 1'b0;
    end else begin
      hdr_pend_d = hdr_pend_q;
    end
    rxy_d = rxy_q;
    cx_d  = cx_q;
    cur_d = cur_q;
`ifdef LBDR_DEROUTE_EN
    dr_d  = dr_q;
`endif
    if (cfg_we) begin
      rxy_d = Rxy_cfg;
      cx_d  = Cx_cfg;
      cur_d = cur_addr_cfg;
`ifdef LBDR_DEROUTE_EN
      dr_d  = dr;
`endif
    end else begin
      cur_d = cur_q;
    end
  end

  // Datapath and configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ports_q     <= 5'b00000;
      rv_q        <= 1'b0;
      no_route_q  <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
      hdr_pend_q  <= 1'b0;
      rxy_q       <= RXY_RST;
      cx_q        <= CX_RST;
      cur_q       <= CUR_ADDR_RST;
`ifdef LBDR_DEROUTE_EN
      dr_q        <= DR_RST;
`endif
    end else begin
      ports_q     <= ports_d;
      rv_q        <= rv_d;
      no_route_q  <= no_route_d;
      proto_err_q <= proto_err_d;
      cnt_q       <= cnt_d;
      hdr_pend_q  <= hdr_pend_d;
      rxy_q       <= rxy_d;
      cx_q        <= cx_d;
      cur_q       <= cur_d;
`ifdef LBDR_DEROUTE_EN
      dr_q        <= dr_d;
`endif
    end
  end

  assign Nport       = ports_q[4];
  assign Eport       = ports_q[3];
  assign Wport       = ports_q[2];
  assign Sport       = ports_q[1];
  assign Lport       = ports_q[0];
  assign route_valid = rv_q;
  assign no_route    = no_route_q;
  assign proto_err   = proto_err_q;
  assign pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_lbdr_param.sv
// Table-driven bench for lbdr_param: per-cycle vectors on a 4x4 instance, hand sequences for
// asynchronous reset mid-packet, and a 3-bit-coordinate instance for counter wrap.
module tb_lbdr_param;

  localparam logic [2:0] H = 3'b001;
  localparam logic [2:0] P = 3'b010;
  localparam logic [2:0] T = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] rxy_cfg = 8'd60;
  logic [3:0] cx_cfg = 4'd15;
  logic [3:0] cur_cfg = 4'd5;
  logic [1:0] dr = 2'd1;
  logic       empty = 1'b1;
  logic       rd = 1'b0;
  logic [2:0] fid = P;
  logic [3:0] dst = 4'd0;
  logic       n_o, e_o, w_o, s_o, l_o, rv_o, nr_o, pe_o;
  logic [7:0] cnt_o;

  logic       empty6 = 1'b1;
  logic       rd6 = 1'b0;
  logic [2:0] fid6 = P;
  logic [5:0] dst6 = 6'd0;
  logic       n6, e6, w6, s6, l6, rv6, nr6, pe6;
  logic [7:0] cnt6;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  lbdr_param dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .Rxy_cfg(rxy_cfg), .Cx_cfg(cx_cfg),
    .cur_addr_cfg(cur_cfg),
`ifdef LBDR_DEROUTE_EN
    .dr(dr),
`endif
    .empty(empty), .rd(rd), .flit_id(fid), .dst_addr(dst),
    .Nport(n_o), .Eport(e_o), .Wport(w_o), .Sport(s_o), .Lport(l_o),
    .route_valid(rv_o), .no_route(nr_o), .proto_err(pe_o), .pkt_cnt(cnt_o)
  );

  lbdr_param #(.X_W(3), .Y_W(3), .CUR_ADDR_RST(6'o33)) dut6 (
    .clk(clk), .rst(rst), .cfg_we(1'b0), .Rxy_cfg(8'd0), .Cx_cfg(4'd0),
    .cur_addr_cfg(6'd0),
`ifdef LBDR_DEROUTE_EN
    .dr(2'd0),
`endif
    .empty(empty6), .rd(rd6), .flit_id(fid6), .dst_addr(dst6),
    .Nport(n6), .Eport(e6), .Wport(w6), .Sport(s6), .Lport(l6),
    .route_valid(rv6), .no_route(nr6), .proto_err(pe6), .pkt_cnt(cnt6)
  );

  typedef struct {
    logic       we;
    logic [3:0] cx;
    logic [3:0] cur;
    logic       empty;
    logic       rd;
    logic [2:0] fid;
    logic [3:0] dst;
    logic [4:0] ep;
    logic       erv;
    logic       enr;
    logic       epe;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic [3:0] cx, input logic [3:0] cur,
                              input logic e, input logic r, input logic [2:0] f,
                              input logic [3:0] d, input logic [4:0] ep, input logic erv,
                              input logic enr, input logic epe, input logic [7:0] ecnt);
    vec_t v;
    v.we = we; v.cx = cx; v.cur = cur; v.empty = e; v.rd = r; v.fid = f; v.dst = d;
    v.ep = ep; v.erv = erv; v.enr = enr; v.epe = epe; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic [15:0] obs();
    return {n_o, e_o, w_o, s_o, l_o, rv_o, nr_o, pe_o, cnt_o};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] cx, input logic [3:0] cur,
                       input logic e, input logic r, input logic [2:0] f, input logic [3:0] d);
    @(negedge clk);
    cfg_we = we; cx_cfg = cx; cur_cfg = cur; empty = e; rd = r; fid = f; dst = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       nr2;
    logic [4:0] p24;
`ifdef LBDR_DEROUTE_EN
    nr2 = 1'b0; p24 = 5'b01000;
`else
    nr2 = 1'b1; p24 = 5'b00000;
`endif
    // we, cx, cur, empty, rd, fid, dst | ports{N,E,W,S,L}, rv, no_route, proto_err, cnt
    vq.push_back(mk(0, 15, 5, 1, 0, P, 0,  5'b00000, 0, 0, 0, 0));
    vq.push_back(mk(0, 15, 5, 0, 1, H, 15, 5'b01000, 1, 0, 0, 0));
    vq.push_back(mk(0, 15, 5, 0, 1, P, 0,  5'b01000, 1, 0, 0, 0));
    vq.push_back(mk(0, 15, 5, 0, 1, T, 0,  5'b00000, 0, 0, 0, 1));
    vq.push_back(mk(0, 15, 5, 0, 1, H, 5,  5'b00001, 1, 0, 0, 1));
    vq.push_back(mk(0, 15, 5, 0, 1, T, 0,  5'b00000, 0, 0, 0, 2));
    vq.push_back(mk(1, 0,  5, 1, 0, P, 0,  5'b00000, 0, 0, 0, 2));
    vq.push_back(mk(0, 15, 5, 0, 1, H, 5,  5'b00001, 1, 0, 0, 2));
    vq.push_back(mk(0, 15, 5, 0, 1, T, 0,  5'b00000, 0, 0, 0, 3));
    vq.push_back(mk(1, 15, 5, 1, 0, P, 0,  5'b00000, 0, 0, 0, 3));
    // header parked at the head for one cycle (rd=0), then consumed
    vq.push_back(mk(0, 15, 5, 0, 0, H, 0,  5'b00100, 1, 0, 0, 3));
    vq.push_back(mk(0, 15, 5, 0, 1, H, 0,  5'b00100, 1, 0, 0, 3));
    vq.push_back(mk(0, 15, 5, 0, 1, T, 0,  5'b00000, 0, 0, 0, 4));
    // north packet, payloads with empty toggling, ignored tails
    vq.push_back(mk(0, 15, 5, 0, 1, H, 1,  5'b10000, 1, 0, 0, 4));
    vq.push_back(mk(0, 15, 5, 0, 1, P, 0,  5'b10000, 1, 0, 0, 4));
    vq.push_back(mk(0, 15, 5, 1, 1, T, 0,  5'b10000, 1, 0, 0, 4));
    vq.push_back(mk(0, 15, 5, 0, 1, P, 0,  5'b10000, 1, 0, 0, 4));
    vq.push_back(mk(0, 15, 5, 1, 0, P, 0,  5'b10000, 1, 0, 0, 4));
    vq.push_back(mk(0, 15, 5, 0, 1, P, 0,  5'b10000, 1, 0, 0, 4));
    vq.push_back(mk(0, 15, 5, 0, 0, T, 0,  5'b10000, 1, 0, 0, 4));
    vq.push_back(mk(0, 15, 5, 0, 1, T, 0,  5'b00000, 0, 0, 0, 5));
    // config write on the header edge: header uses the old Cx
    vq.push_back(mk(1, 14, 5, 0, 1, H, 15, 5'b01000, 1, 0, 0, 5));
    vq.push_back(mk(0, 14, 5, 0, 1, P, 0,  5'b01000, 1, 0, 0, 5));
    vq.push_back(mk(0, 14, 5, 0, 1, T, 0,  5'b00000, 0, 0, 0, 6));
    vq.push_back(mk(0, 14, 5, 0, 1, H, 1,  p24,      1, nr2, 0, 6));
    vq.push_back(mk(0, 14, 5, 0, 1, T, 0,  5'b00000, 0, nr2, 0, 7));
    vq.push_back(mk(1, 15, 5, 1, 0, P, 0,  5'b00000, 0, nr2, 0, 7));
    // protocol errors: payload in IDLE, second header in ROUTE
    vq.push_back(mk(0, 15, 5, 0, 1, P, 0,  5'b00000, 0, nr2, 1, 7));
    vq.push_back(mk(0, 15, 5, 0, 1, H, 15, 5'b01000, 1, nr2, 1, 7));
    vq.push_back(mk(0, 15, 5, 0, 1, H, 1,  5'b10000, 1, nr2, 1, 7));
    vq.push_back(mk(0, 15, 5, 0, 1, T, 0,  5'b00000, 0, nr2, 1, 8));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs(), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].we, vq[i].cx, vq[i].cur, vq[i].empty, vq[i].rd, vq[i].fid, vq[i].dst);
      chk($sformatf("vec%0d", i), obs(),
          {vq[i].ep, vq[i].erv, vq[i].enr, vq[i].epe, vq[i].ecnt});
    end

    // New node address makes dst F local; then async reset mid-packet.
    drive(1, 15, 4'hF, 1, 0, P, 0);
    drive(0, 15, 4'hF, 0, 1, H, 15);
    chk("cur_cfg_local", obs(), {5'b00001, 1'b1, nr2, 1'b1, 8'd8});
    drive(0, 15, 4'hF, 0, 1, P, 0);
    @(negedge clk);
    empty = 1'b1; rd = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset", obs(), 16'h0000);
    #1 rst = 1'b0;
    drive(0, 15, 4'hF, 0, 1, H, 15);
    chk("post_reset_cfg", obs(), {5'b01000, 1'b1, 1'b0, 1'b0, 8'd0});
    drive(0, 15, 4'hF, 0, 1, T, 0);
    chk("post_reset_tail", obs(), {5'b00000, 1'b0, 1'b0, 1'b0, 8'd1});

    // Wide-coordinate instance: 257 packets east, counter wraps to 1.
    for (int k = 0; k < 257; k++) begin
      @(negedge clk);
      empty6 = 1'b0; rd6 = 1'b1; fid6 = H; dst6 = 6'o34;
      @(posedge clk);
      #1;
      chk($sformatf("w6_hdr%0d", k), {8'd0, n6, e6, w6, s6, l6, rv6, nr6, pe6},
          {8'd0, 5'b01000, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      fid6 = T;
      @(posedge clk);
      #1;
      chk($sformatf("w6_tail%0d", k), {n6, e6, w6, s6, l6, rv6, nr6, pe6, cnt6},
          {5'b00000, 1'b0, 1'b0, 1'b0, 8'((k + 1) % 256)});
    end
    chk("w6_wrap", {8'd0, cnt6}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
